// File: rtl/guess_game_ctrl.sv
// Guessing-game sequencer: latches a BCD secret from a free-running counter,
// strobes an external BCD comparator for each guess and tracks remaining tries.
module guess_game_ctrl #(
  parameter int unsigned MAX_TRIES = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        submit_btn,
  input  logic [15:0] guess,
  input  logic        cmp_eq,
  input  logic        cmp_gt,
  input  logic        cmp_sm,
  output logic        cmp_state,
  output logic        cmp_submit,
  output logic [15:0] secret,
  output logic [3:0]  tries_left,
  output logic [1:0]  hint,
  output logic        win,
  output logic        lose,
  output logic        busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PLAY  = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] EVAL  = 3'd4;
  localparam logic [2:0] WIN   = 3'd5;
  localparam logic [2:0] LOSE  = 3'd6;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        start_prev;
  logic        submit_prev;
  logic        start_edge;
  logic        submit_edge;
  logic [15:0] count;
  logic [15:0] count_inc;
  logic        guess_valid;
  logic [3:0]  tries_dec;

  assign start_edge  = start_btn & ~start_prev;
  assign submit_edge = submit_btn & ~submit_prev;
  assign tries_dec   = tries_left - 4'd1;

  // Digit-wise BCD increment of the secret source counter, 9999 wraps to 0000
  always_comb begin
    logic carry;
    count_inc = count;
    carry     = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = '0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // A guess is usable only when every digit is a decimal digit
  always_comb begin
    guess_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (guess[4*i +: 4] > 4'd9) guess_valid = 1'b0;
    end
  end

  // Next-state logic; start takes priority over submit in PLAY
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_edge) next_state = PLAY;
      PLAY: begin
        if (start_edge)                      next_state = IDLE;
        else if (submit_edge && guess_valid) next_state = PULSE;
      end
      PULSE: next_state = WAIT;
      WAIT:  next_state = EVAL;
      EVAL: begin
        if (cmp_eq)               next_state = WIN;
        else if (tries_dec == '0) next_state = LOSE;
        else                      next_state = PLAY;
      end
      WIN, LOSE: if (start_edge) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // State and state-decoded outputs are registered from next_state so the
  // comparator strobe and enable are glitch-free flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmp_state  <= 1'b0;
      cmp_submit <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      cmp_state  <= (next_state != IDLE);
      cmp_submit <= (next_state == PULSE);
      win        <= (next_state == WIN);
      lose       <= (next_state == LOSE);
      busy       <= (next_state == PULSE) || (next_state == WAIT) ||
                    (next_state == EVAL);
    end
  end

  // Datapath: button history, secret counter, secret latch, tries and hint
  always_ff @(posedge clk) begin
    if (rst) begin
      start_prev  <= 1'b1;
      submit_prev <= 1'b1;
      count       <= '0;
      secret      <= '0;
      tries_left  <= '0;
      hint        <= '0;
    end else begin
      start_prev  <= start_btn;
      submit_prev <= submit_btn;
      if (state == IDLE) count <= count_inc;
      case (state)
        IDLE: begin
          hint <= '0;
          if (start_edge) begin
            secret     <= count;
            tries_left <= 4'(MAX_TRIES);
          end
        end
        PLAY: begin
          if (start_edge)                       hint <= '0;
          else if (submit_edge && !guess_valid) hint <= 2'b11;
        end
        EVAL: begin
          if (cmp_eq) begin
            hint <= '0;
          end else begin
            tries_left <= tries_dec;
            if (tries_dec != '0) begin
              if (cmp_sm)      hint <= 2'b01;
              else if (cmp_gt) hint <= 2'b10;
              else             hint <= 2'b00;
            end
          end
        end
        WIN, LOSE: if (start_edge) hint <= '0;
        default: ;
      endcase
    end
  end

endmodule
